// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin two-port arbiter/sequencer for the shared ALU.
//               One op in flight: IDLE -> EXEC -> RESP -> IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int XLEN = 64,
    parameter int OP_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [XLEN-1:0] req0_src1,
    input  logic [XLEN-1:0] req0_src2,
    input  logic            req0_32,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [XLEN-1:0] req1_src1,
    input  logic [XLEN-1:0] req1_src2,
    input  logic            req1_32,

    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_result,
    output logic            resp0_err,

    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_result,
    output logic            resp1_err,

    output logic [OP_W-1:0] alu_op_o,
    output logic [XLEN-1:0] alu_src1_o,
    output logic [XLEN-1:0] alu_src2_o,
    output logic            alu_32_o,
    input  logic [XLEN-1:0] alu_result_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q,      owner_d;
    logic [OP_W-1:0] op_q,         op_d;
    logic [XLEN-1:0] src1_q,       src1_d;
    logic [XLEN-1:0] src2_q,       src2_d;
    logic            w32_q,        w32_d;
    logic            illegal_q,    illegal_d;
    logic [XLEN-1:0] result_q,     result_d;
    logic            err_q,        err_d;

    logic            grant0;
    logic            grant1;
    logic [OP_W-1:0] sel_op;
    logic [XLEN-1:0] sel_src1;
    logic [XLEN-1:0] sel_src2;
    logic            sel_w32;

    // On a tie the port that did not win last time is granted; the two
    // grants are mutually exclusive by construction.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    always_comb begin
        sel_op   = grant1 ? req1_op   : req0_op;
        sel_src1 = grant1 ? req1_src1 : req0_src1;
        sel_src2 = grant1 ? req1_src2 : req0_src2;
        sel_w32  = grant1 ? req1_32   : req0_32;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            w32_q        <= 1'b0;
            illegal_q    <= 1'b0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            w32_q        <= w32_d;
            illegal_q    <= illegal_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        w32_d        = w32_q;
        illegal_d    = illegal_q;
        result_d     = result_q;
        err_d        = err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        alu_op_o     = '0;

        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 | grant1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    op_d         = sel_op;
                    src1_d       = sel_src1;
                    src2_d       = sel_src2;
                    w32_d        = sel_w32;
                    illegal_d    = ~$onehot(sel_op);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // A malformed op is kept off the ALU bus and answered with 0.
                alu_op_o = illegal_q ? '0 : op_q;
                result_d = illegal_q ? '0 : alu_result_i;
                err_d    = illegal_q;
                state_d  = RESP;
            end
            RESP: begin
                resp0_valid = ~owner_q;
                resp1_valid = owner_q;
                if (owner_q ? resp1_ready : resp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        alu_src1_o   = src1_q;
        alu_src2_o   = src2_q;
        alu_32_o     = w32_q;
        resp0_result = owner_q ? '0 : result_q;
        resp1_result = owner_q ? result_q : '0;
        resp0_err    = ~owner_q & err_q;
        resp1_err    = owner_q & err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Self-checking bench for alu_share_arb with a reference ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [11:0] req0_op = '0, req1_op = '0;
    logic [63:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
    logic        req0_32 = 1'b0, req1_32 = 1'b0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [63:0] resp0_result, resp1_result;
    logic        resp0_err, resp1_err;
    logic [11:0] alu_op_o;
    logic [63:0] alu_src1_o, alu_src2_o;
    logic        alu_32_o;
    logic [63:0] alu_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.XLEN(64), .OP_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_32(req0_32),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_32(req1_32),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_err(resp1_err),
        .alu_op_o(alu_op_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_32_o(alu_32_o), .alu_result_i(alu_res)
    );

    // Op bits, MSB first: add sub slt sltu and or xor sll srl sra nop sp.
    function automatic logic [63:0] ref_alu(input logic [11:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic w);
        logic [63:0]        r;
        logic signed [63:0] sa;
        logic [5:0]         sh;
        sh = w ? {1'b0, b[4:0]} : b[5:0];
        sa = w ? {{32{a[31]}}, a[31:0]} : a;
        case (op)
            12'h800: r = a + b;
            12'h400: r = a - b;
            12'h200: r = w ? 64'($signed(a[31:0]) < $signed(b[31:0])) : 64'($signed(a) < $signed(b));
            12'h100: r = w ? 64'(a[31:0] < b[31:0]) : 64'(a < b);
            12'h080: r = a & b;
            12'h040: r = a | b;
            12'h020: r = a ^ b;
            12'h010: r = a << sh;
            12'h008: r = w ? ({32'd0, a[31:0]} >> sh) : (a >> sh);
            12'h004: r = sa >>> sh;
            12'h002: r = a;
            12'h001: r = b;
            default: r = '0;
        endcase
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    assign alu_res = ref_alu(alu_op_o, alu_src1_o, alu_src2_o, alu_32_o);

    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 waiting, 1 on the ALU, 2 answering.
    int          m_phase = 0;
    int          m_p;
    logic        m_last = 1'b1, m_owner = 1'b0, m_err = 1'b0, m_w = 1'b0;
    logic        m_acc0 = 1'b0, m_acc1 = 1'b0;
    logic [11:0] m_op = '0;
    logic [63:0] m_s1 = '0, m_s2 = '0, m_res = '0;
    int          grants[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_err = 1'b0; m_w = 1'b0;
            m_op = '0; m_s1 = '0; m_s2 = '0; m_res = '0; m_acc0 = 1'b0; m_acc1 = 1'b0;
        end else begin
            m_acc0 = 1'b0;
            m_acc1 = 1'b0;
            if (m_phase == 0) begin
                m_p = pick(req0_valid, req1_valid, m_last);
                if (m_p >= 0) begin
                    m_owner = (m_p == 1);
                    m_last  = (m_p == 1);
                    m_op    = m_owner ? req1_op   : req0_op;
                    m_s1    = m_owner ? req1_src1 : req0_src1;
                    m_s2    = m_owner ? req1_src2 : req0_src2;
                    m_w     = m_owner ? req1_32   : req0_32;
                    m_err   = ($countones(m_op) != 1);
                    m_res   = m_err ? 64'd0 : ref_alu(m_op, m_s1, m_s2, m_w);
                    m_acc0  = !m_owner;
                    m_acc1  = m_owner;
                    grants.push_back(m_p);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_owner ? resp1_ready : resp0_ready) begin
                m_phase = 0;
            end
        end
    end

    int e_pick;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            chk("rst_req0_ready", 64'(req0_ready), 64'd0);
            chk("rst_req1_ready", 64'(req1_ready), 64'd0);
            chk("rst_resp0_valid", 64'(resp0_valid), 64'd0);
            chk("rst_resp1_valid", 64'(resp1_valid), 64'd0);
            chk("rst_resp0_result", resp0_result, 64'd0);
            chk("rst_resp1_result", resp1_result, 64'd0);
            chk("rst_errs", 64'({resp0_err, resp1_err}), 64'd0);
            chk("rst_alu_op", 64'(alu_op_o), 64'd0);
            chk("rst_alu_src1", alu_src1_o, 64'd0);
            chk("rst_alu_src2", alu_src2_o, 64'd0);
            chk("rst_alu_32", 64'(alu_32_o), 64'd0);
        end else begin
            e_pick = (m_phase == 0) ? pick(req0_valid, req1_valid, m_last) : -1;
            chk("req0_ready", 64'(req0_ready), 64'(e_pick == 0));
            chk("req1_ready", 64'(req1_ready), 64'(e_pick == 1));
            chk("resp0_valid", 64'(resp0_valid), 64'(m_phase == 2 && !m_owner));
            chk("resp1_valid", 64'(resp1_valid), 64'(m_phase == 2 && m_owner));
            chk("alu_op", 64'(alu_op_o), 64'((m_phase == 1 && !m_err) ? m_op : 12'd0));
            if (m_phase == 1) begin
                chk("alu_src1", alu_src1_o, m_s1);
                chk("alu_src2", alu_src2_o, m_s2);
                chk("alu_32", 64'(alu_32_o), 64'(m_w));
            end
            if (m_phase == 2 && !m_owner) begin
                chk("resp0_result", resp0_result, m_res);
                chk("resp0_err", 64'(resp0_err), 64'(m_err));
            end
            if (m_phase == 2 && m_owner) begin
                chk("resp1_result", resp1_result, m_res);
                chk("resp1_err", 64'(resp1_err), 64'(m_err));
            end
        end
    end

    // Advance to the next falling edge; a request accepted at the last
    // rising edge is withdrawn.
    task automatic tick();
        @(negedge clk);
        if (m_acc0) req0_valid = 1'b0;
        if (m_acc1) req1_valid = 1'b0;
    endtask

    task automatic drive(input int p, input logic [11:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic w);
        if (p == 0) begin
            req0_op = op; req0_src1 = a; req0_src2 = b; req0_32 = w; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_src1 = a; req1_src2 = b; req1_32 = w; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_resp(input int p, output logic [63:0] r, output logic e);
        bit got;
        got = 1'b0;
        r = '0;
        e = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            #2;
            if (p == 0 ? resp0_valid : resp1_valid) begin
                got = 1'b1;
                r = (p == 0) ? resp0_result : resp1_result;
                e = (p == 0) ? resp0_err : resp1_err;
            end
        end
        chk("resp_timeout", 64'(got), 64'd1);
    endtask

    logic [63:0] r, held;
    logic        e;
    int          s;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;

        // Tie straight after reset: port 0 first, then port 1.
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        drive(0, 12'h400, 64'd10, 64'd3, 1'b0);
        drive(1, 12'h020, 64'hF0, 64'h0F, 1'b0);
        #2;
        chk("tie_ready0", 64'(req0_ready), 64'd1);
        chk("tie_ready1", 64'(req1_ready), 64'd0);
        wait_resp(0, r, e);
        chk("tie_res0", r, 64'd7);
        wait_resp(1, r, e);
        chk("tie_res1", r, 64'hFF);

        // Single op on port 0, cycle by cycle.
        tick();
        drive(0, 12'h800, 64'd5, 64'd7, 1'b0);
        #2;
        chk("single_ready", 64'(req0_ready), 64'd1);
        tick(); #2;
        chk("single_aluop", 64'(alu_op_o), 64'h800);
        tick(); #2;
        chk("single_valid", 64'(resp0_valid), 64'd1);
        chk("single_res", resp0_result, 64'd12);
        chk("single_err", 64'(resp0_err), 64'd0);
        chk("single_v1", 64'(resp1_valid), 64'd0);
        tick(); #2;
        chk("single_done", 64'(resp0_valid), 64'd0);

        // Backpressure on port 1 while port 0 waits.
        resp1_ready = 1'b0;
        drive(0, 12'h400, 64'd100, 64'd1, 1'b0);
        drive(1, 12'h080, 64'hF0F0, 64'hFF00, 1'b0);
        wait_resp(1, held, e);
        chk("bp_res", held, 64'hF000);
        for (int i = 0; i < 5; i++) begin
            tick(); #2;
            chk("bp_valid", 64'(resp1_valid), 64'd1);
            chk("bp_hold", resp1_result, held);
            chk("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
        end
        resp1_ready = 1'b1;
        tick(); #2;
        chk("bp_release", 64'(resp1_valid), 64'd0);
        wait_resp(0, r, e);
        chk("bp_res0", r, 64'd99);

        // Malformed op on port 0.
        tick();
        drive(0, 12'h003, 64'd1, 64'd2, 1'b0);
        wait_resp(0, r, e);
        chk("illegal_res", r, 64'd0);
        chk("illegal_err", 64'(e), 64'd1);

        // Fairness under continuous demand; last winner was port 0.
        s = grants.size();
        for (int i = 0; i < 60 && grants.size() < s + 6; i++) begin
            tick();
            if (!req0_valid) drive(0, 12'h800, rnd64(), rnd64(), 1'b0);
            if (!req1_valid) drive(1, 12'h400, rnd64(), rnd64(), 1'b1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("fair_count", 64'(grants.size() - s >= 6), 64'd1);
        for (int i = 0; i < 6; i++) begin
            if (s + i < grants.size()) chk("fair_grant", 64'(grants[s + i]), 64'((i % 2 == 0) ? 1 : 0));
        end
        repeat (4) tick();

        // Reset while an op is on the ALU.
        drive(0, 12'h800, 64'd1, 64'd2, 1'b0);
        tick();
        rst_n = 1'b0;
        #2;
        chk("rstx_aluop", 64'(alu_op_o), 64'd0);
        chk("rstx_src1", alu_src1_o, 64'd0);
        chk("rstx_valid", 64'({resp0_valid, resp1_valid}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(0, 12'h020, 64'd3, 64'd5, 1'b0);
        drive(1, 12'h080, 64'd3, 64'd5, 1'b0);
        #2;
        chk("rstx_tie0", 64'(req0_ready), 64'd1);
        chk("rstx_tie1", 64'(req1_ready), 64'd0);
        wait_resp(0, r, e);
        chk("rstx_res0", r, 64'd6);
        wait_resp(1, r, e);
        chk("rstx_res1", r, 64'd1);

        // Random traffic checked by the model.
        for (int i = 0; i < 600; i++) begin
            tick();
            if (!req0_valid) begin
                if ($urandom_range(0, 2) == 0)
                    drive(0, ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'd1 << $urandom_range(0, 11),
                          rnd64(), rnd64(), 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid) begin
                if ($urandom_range(0, 2) == 0)
                    drive(1, ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'd1 << $urandom_range(0, 11),
                          rnd64(), rnd64(), 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            resp0_ready = 1'($urandom_range(0, 1));
            resp1_ready = 1'($urandom_range(0, 1));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
